// File: rtl/operand_issuer.sv
// operand_issuer: buffers tagged operand pairs, issues one packed {a,b} word per cycle into the
// add pipeline and re-tags its results. Define OPERAND_ISSUER_PERF_EN for issue/bubble counters.
module operand_issuer #(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [15:0]            op_a,
    input  logic [15:0]            op_b,
    input  logic [TAG_W-1:0]       op_tag,
    output logic [31:0]            instr_out,
    input  logic [31:0]            pipe_result,
    output logic                   res_valid,
    output logic [TAG_W-1:0]       res_tag,
    output logic [31:0]            res_data,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef OPERAND_ISSUER_PERF_EN
    ,
    output logic [15:0]            issued_cnt,
    output logic [15:0]            bubble_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 32 + TAG_W;

    logic [ENT_W-1:0]             mem_q [DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [31:0]                  instr_q, instr_d;
    logic [PIPE_LAT:0]            vld_q, vld_d;
    logic [PIPE_LAT:0][TAG_W-1:0] tag_q, tag_d;
    logic [ENT_W-1:0]             head;
    logic                         push;
    logic                         issue_en;

    // Handshake: a pair transfers on a rising edge where op_valid && op_ready; op_ready
    // depends only on the registered occupancy, so a full FIFO refuses even while popping.
    assign issue_en = (count_q != '0);

    always_comb begin
        op_ready = reset_n && (count_q < CNT_W'(DEPTH));
        push     = op_valid && op_ready;
        head     = mem_q[rd_ptr_q];
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = issue_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(issue_en);
        instr_d  = issue_en ? head[ENT_W-1:TAG_W] : 32'h0;
        // Tag delay line mirrors pipeline latency; bubbles carry valid=0, tag=0.
        vld_d    = {vld_q[PIPE_LAT-1:0], issue_en};
        tag_d    = {tag_q[PIPE_LAT-1:0], (issue_en ? head[TAG_W-1:0] : TAG_W'(0))};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {op_a, op_b, op_tag};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= '0;
            vld_q    <= '0;
            tag_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            vld_q    <= vld_d;
            tag_q    <= tag_d;
        end
    end

    assign instr_out  = instr_q;
    assign fifo_count = count_q;
    assign res_valid  = vld_q[PIPE_LAT];
    assign res_tag    = tag_q[PIPE_LAT];
    assign res_data   = pipe_result;

`ifdef OPERAND_ISSUER_PERF_EN
    logic [15:0] issued_q;
    logic [15:0] bubble_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_q <= '0;
            bubble_q <= '0;
        end else if (issue_en) begin
            issued_q <= issued_q + 16'd1;
        end else begin
            bubble_q <= bubble_q + 16'd1;
        end
    end

    assign issued_cnt = issued_q;
    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_operand_issuer.sv
// Self-checking bench for operand_issuer: behavioural pipeline + queue-based reference model,
// directed test-plan scenarios followed by randomized traffic with stalls and resets.
module tb_operand_issuer;
    localparam int DEPTH    = 4;
    localparam int TAG_W    = 4;
    localparam int PIPE_LAT = 3;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int SB_W     = TAG_W + 32;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [15:0]       op_a     = '0;
    logic [15:0]       op_b     = '0;
    logic [TAG_W-1:0]  op_tag   = '0;
    logic [31:0]       instr_out;
    logic [31:0]       pipe_result;
    logic              res_valid;
    logic [TAG_W-1:0]  res_tag;
    logic [31:0]       res_data;
    logic [CNT_W-1:0]  fifo_count;
`ifdef OPERAND_ISSUER_PERF_EN
    logic [15:0]       issued_cnt;
    logic [15:0]       bubble_cnt;
`endif

    operand_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_tag      (op_tag),
        .instr_out   (instr_out),
        .pipe_result (pipe_result),
        .res_valid   (res_valid),
        .res_tag     (res_tag),
        .res_data    (res_data),
        .fifo_count  (fifo_count)
`ifdef OPERAND_ISSUER_PERF_EN
        ,
        .issued_cnt  (issued_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Behavioural two-stage-plus adder: result appears PIPE_LAT edges after instr_out changes.
    logic [31:0] pipe_s [PIPE_LAT];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_LAT; i++) pipe_s[i] <= '0;
        end else begin
            pipe_s[0] <= {16'h0, instr_out[31:16]} + {16'h0, instr_out[15:0]};
            for (int i = 1; i < PIPE_LAT; i++) pipe_s[i] <= pipe_s[i-1];
        end
    end
    assign pipe_result = pipe_s[PIPE_LAT-1];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [TAG_W-1:0] tag;
    } pair_t;

    typedef struct {
        int unsigned      due;
        logic [TAG_W-1:0] tag;
        logic [31:0]      sum;
    } flight_t;

    pair_t            m_fifo[$];
    flight_t          m_flight[$];
    logic [SB_W-1:0]  exp_q[$];
    logic [SB_W-1:0]  got_q[$];
    int unsigned      got_edge_q[$];
    int unsigned      m_edge   = 0;
    int unsigned      m_issued = 0;
    int unsigned      m_bubble = 0;
    logic [31:0]      m_instr  = '0;
    logic             m_rv     = 1'b0;
    logic [TAG_W-1:0] m_rtag   = '0;
    logic [31:0]      m_rdata  = '0;
    logic             stall    = 1'b0;

    task automatic model_step();
        pair_t   p;
        flight_t f;
        bit      do_pop;
        bit      do_push;
        if (!reset_n) begin
            m_fifo.delete();
            m_flight.delete();
            exp_q.delete();
            m_edge = 0; m_issued = 0; m_bubble = 0;
            m_instr = '0; m_rv = 1'b0; m_rtag = '0; m_rdata = '0;
            return;
        end
        m_edge++;
        do_pop  = (m_fifo.size() != 0) && !stall;
        do_push = op_valid && (m_fifo.size() < DEPTH);
        if (do_pop) begin
            p = m_fifo.pop_front();
            m_instr = {p.a, p.b};
            m_flight.push_back('{m_edge + PIPE_LAT, p.tag, 32'(p.a) + 32'(p.b)});
            m_issued++;
        end else begin
            m_instr = '0;
            m_bubble++;
        end
        if (do_push) begin
            m_fifo.push_back('{op_a, op_b, op_tag});
            exp_q.push_back({op_tag, 32'(op_a) + 32'(op_b)});
        end
        m_rv = 1'b0; m_rtag = '0; m_rdata = '0;
        if (m_flight.size() != 0 && m_flight[0].due == m_edge) begin
            f = m_flight.pop_front();
            m_rv = 1'b1; m_rtag = f.tag; m_rdata = f.sum;
        end
    endtask

    // Monitor: one model step and a full output comparison just after every rising edge.
    logic [SB_W-1:0] sb_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
            check_eq("instr_out", 64'(instr_out), 64'(m_instr));
            check_eq("res_valid", 64'(res_valid), 64'(m_rv));
            check_eq("res_tag", 64'(res_tag), 64'(m_rtag));
            if (m_rv) check_eq("res_data", 64'(res_data), 64'(m_rdata));
            check_eq("fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
            check_eq("op_ready", 64'(op_ready), 64'(reset_n && (m_fifo.size() < DEPTH)));
`ifdef OPERAND_ISSUER_PERF_EN
            check_eq("issued_cnt", 64'(issued_cnt), 64'(m_issued & 32'hFFFF));
            check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble & 32'hFFFF));
`endif
            if (res_valid) begin
                got_q.push_back({res_tag, res_data});
                got_edge_q.push_back(m_edge);
                check_eq("sb_pending", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    sb_e = exp_q.pop_front();
                    check_eq("sb_result", 64'({res_tag, res_data}), 64'(sb_e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [TAG_W-1:0] t);
        @(negedge clk);
        op_valid = v;
        op_a     = a;
        op_b     = b;
        op_tag   = t;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 16'($urandom), TAG_W'($urandom));
    endtask

    task automatic clear_capture();
        got_q.delete();
        got_edge_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset
        idle(10);
        check_eq("idle_ready", 64'(op_ready), 64'(1));
        check_eq("idle_instr", 64'(instr_out), 64'(0));

        // Single accept: accepted at edge N
        clear_capture();
        drive(1'b1, 16'h0003, 16'h0005, 4'h2);
        drive(1'b0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
        check_eq("single_instr", 64'(instr_out), 64'h0003_0005);
        repeat (2) @(negedge clk);
        check_eq("single_early", 64'(res_valid), 64'(0));
        @(negedge clk);
        check_eq("single_valid", 64'(res_valid), 64'(1));
        check_eq("single_tag", 64'(res_tag), 64'(2));
        check_eq("single_data", 64'(res_data), 64'h8);
        @(negedge clk);
        check_eq("single_pulse_len", 64'(res_valid), 64'(0));

        // Back-to-back burst of 8
        idle(4);
        clear_capture();
        for (int i = 0; i < 8; i++) drive(1'b1, 16'(i), 16'h0100, TAG_W'(i));
        idle(10);
        check_eq("burst_count", 64'(got_q.size()), 64'(8));
        if (got_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_eq("burst_result", 64'(got_q[i]), 64'({TAG_W'(i), 32'(32'h100 + i)}));
                check_eq("burst_consecutive", 64'(got_edge_q[i] - got_edge_q[0]), 64'(i));
            end
        end

        // Fill with issue held off
        clear_capture();
        @(negedge clk);
        stall = 1'b1;
        force dut.issue_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 16'(16'h1000 + i), 16'(i), TAG_W'(8 + i));
        drive(1'b1, 16'hDEAD, 16'hBEEF, 4'hE);
        check_eq("full_count", 64'(fifo_count), 64'(DEPTH));
        check_eq("full_ready", 64'(op_ready), 64'(0));
        @(negedge clk);
        check_eq("full_reject", 64'(fifo_count), 64'(DEPTH));
        op_valid = 1'b0;
        stall = 1'b0;
        release dut.issue_en;
        idle(12);
        check_eq("fill_drain_count", 64'(got_q.size()), 64'(DEPTH));
        if (got_q.size() == DEPTH) begin
            for (int i = 0; i < DEPTH; i++)
                check_eq("fill_result", 64'(got_q[i]), 64'({TAG_W'(8 + i), 32'(32'h1000 + 2 * i)}));
        end

        // Reset with pairs queued / in flight
        clear_capture();
        for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'h0200 + i), 16'h0010, TAG_W'(4 + i));
        drive(1'b0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("rst_instr", 64'(instr_out), 64'(0));
        check_eq("rst_res_valid", 64'(res_valid), 64'(0));
        check_eq("rst_res_tag", 64'(res_tag), 64'(0));
        check_eq("rst_count", 64'(fifo_count), 64'(0));
        check_eq("rst_ready", 64'(op_ready), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(8);
        check_eq("rst_no_stale", 64'(got_q.size()), 64'(0));
        drive(1'b1, 16'hFFFF, 16'h0001, 4'hF);
        idle(6);
        check_eq("rst_new_count", 64'(got_q.size()), 64'(1));
        if (got_q.size() == 1) check_eq("rst_new_result", 64'(got_q[0]), 64'({4'hF, 32'h0001_0000}));

        // Randomized traffic with random stalls and occasional resets
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            op_valid = ($urandom_range(0, 3) != 0);
            op_a     = 16'($urandom);
            op_b     = 16'($urandom);
            op_tag   = TAG_W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                stall = ~stall;
                if (stall) force dut.issue_en = 1'b0;
                else release dut.issue_en;
            end
            reset_n = ($urandom_range(0, 149) != 0);
        end
        @(negedge clk);
        op_valid = 1'b0;
        stall    = 1'b0;
        release dut.issue_en;
        reset_n  = 1'b1;
        idle(12);
        check_eq("random_drained", 64'(exp_q.size()), 64'(0));

`ifdef OPERAND_ISSUER_PERF_EN
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 16'(i), 16'(i), TAG_W'(i));
        idle(20);
        check_eq("perf_issued", 64'(issued_cnt), 64'(5));
        check_eq("perf_bubble", 64'(bubble_cnt), 64'(m_edge - 5));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
